// File: rtl/paquete_comparador.sv
// Shared definitions for the serial comparator: funct3 codes, FSM states, helpers.
package paquete_comparador;

  localparam logic [2:0] F_EQ  = 3'b000;
  localparam logic [2:0] F_NE  = 3'b001;
  localparam logic [2:0] F_LT  = 3'b100;
  localparam logic [2:0] F_GE  = 3'b101;
  localparam logic [2:0] F_LTU = 3'b110;
  localparam logic [2:0] F_GEU = 3'b111;

  typedef enum logic [1:0] {
    INACTIVO,
    COMPARANDO,
    RESULTADO
  } estado_t;

  // Signed modes are handled by flipping the sign bits and comparing unsigned.
  function automatic logic es_con_signo(input logic [2:0] funcion);
    return (funcion == F_LT) || (funcion == F_GE);
  endfunction

endpackage

// File: rtl/comparador_serie_if.sv
// Request/result handshake bundle between a requester and the serial comparator.
interface comparador_serie_if #(
  parameter int unsigned ANCHO = 32
);
  logic [ANCHO-1:0] a;
  logic [ANCHO-1:0] b;
  logic [2:0]       funcion;
  logic             entrada_valida;
  logic             entrada_lista;
  logic             salida_valida;
  logic             salida_lista;
  logic             resultado;
  logic [ANCHO-1:0] Y;
  logic             error;

  modport master (
    output a, b, funcion, entrada_valida, salida_lista,
    input  entrada_lista, salida_valida, resultado, Y, error
  );

  modport slave (
    input  a, b, funcion, entrada_valida, salida_lista,
    output entrada_lista, salida_valida, resultado, Y, error
  );
endinterface

// File: rtl/comparador_digito.sv
// Combinational unsigned compare of one DIGITO-bit slice.
module comparador_digito #(
  parameter int unsigned DIGITO = 8
) (
  input  logic [DIGITO-1:0] a,
  input  logic [DIGITO-1:0] b,
  output logic              menor,
  output logic              igual
);

  // Plain magnitude compare; the caller handles signedness.
  always_comb begin
    menor = (a < b);
    igual = (a == b);
  end

endmodule

// File: rtl/comparador_serie.sv
// Multi-cycle RV32I branch/SLT comparator: walks operand slices MSB-first, stops at
// the first differing slice and holds the verdict until the consumer takes it.
module comparador_serie
  import paquete_comparador::*;
#(
  parameter int unsigned ANCHO  = 32,
  parameter int unsigned DIGITO = 8
) (
  input logic               clk,
  input logic               nreset,
  comparador_serie_if.slave bus
);

  localparam int unsigned NumSlices = ANCHO / DIGITO;
  localparam int unsigned IdxW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  estado_t           estado_q, estado_d;
  logic [ANCHO-1:0]  a_q, a_d;
  logic [ANCHO-1:0]  b_q, b_d;
  logic [2:0]        funcion_q, funcion_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              resultado_q, resultado_d;
  logic              error_q, error_d;

  logic [DIGITO-1:0] digito_a;
  logic [DIGITO-1:0] digito_b;
  logic              menor;
  logic              igual;

  // Select the slice under comparison; shifting avoids a zero-width index when N=1.
  always_comb begin
    digito_a = DIGITO'(a_q >> (32'(idx_q) * DIGITO));
    digito_b = DIGITO'(b_q >> (32'(idx_q) * DIGITO));
  end

  comparador_digito #(
    .DIGITO(DIGITO)
  ) u_digito (
    .a    (digito_a),
    .b    (digito_b),
    .menor(menor),
    .igual(igual)
  );

  // Next-state logic: latch on accept, scan slices, resolve verdict, wait for consumer.
  always_comb begin
    estado_d    = estado_q;
    a_d         = a_q;
    b_d         = b_q;
    funcion_d   = funcion_q;
    idx_d       = idx_q;
    resultado_d = resultado_q;
    error_d     = error_q;

    unique case (estado_q)
      INACTIVO: begin
        if (bus.entrada_valida) begin
          a_d       = bus.a;
          b_d       = bus.b;
          if (es_con_signo(bus.funcion)) begin
            a_d[ANCHO-1] = ~bus.a[ANCHO-1];
            b_d[ANCHO-1] = ~bus.b[ANCHO-1];
          end
          funcion_d = bus.funcion;
          idx_d     = IdxW'(NumSlices - 1);
          estado_d  = COMPARANDO;
        end
      end

      COMPARANDO: begin
        if (!igual || (idx_q == '0)) begin
          // Reaching here with igual set means every slice matched.
          error_d  = 1'b0;
          estado_d = RESULTADO;
          case (funcion_q)
            F_EQ:         resultado_d = igual;
            F_NE:         resultado_d = ~igual;
            F_LT, F_LTU:  resultado_d = menor;
            F_GE, F_GEU:  resultado_d = ~menor;
            default: begin
              resultado_d = 1'b0;
              error_d     = 1'b1;
            end
          endcase
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end

      RESULTADO: begin
        if (bus.salida_lista) begin
          resultado_d = 1'b0;
          error_d     = 1'b0;
          estado_d    = INACTIVO;
        end
      end

      default: estado_d = INACTIVO;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      estado_q    <= INACTIVO;
      a_q         <= '0;
      b_q         <= '0;
      funcion_q   <= '0;
      idx_q       <= '0;
      resultado_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      a_q         <= a_d;
      b_q         <= b_d;
      funcion_q   <= funcion_d;
      idx_q       <= idx_d;
      resultado_q <= resultado_d;
      error_q     <= error_d;
    end
  end

  // Handshake flags come from state alone; no path from entrada_valida to entrada_lista.
  always_comb begin
    bus.entrada_lista = (estado_q == INACTIVO);
    bus.salida_valida = (estado_q == RESULTADO);
    bus.resultado     = resultado_q;
    bus.Y             = ANCHO'(resultado_q);
    bus.error         = error_q;
  end

endmodule

// File: tb/tb_comparador_serie.sv
// Bench for comparador_serie: four instances (DIGITO 8, 1, 4, 32) share the same
// stimulus; each transaction is checked against an arithmetic reference model.
module tb_comparador_serie;
  import paquete_comparador::*;

  logic        clk;
  logic        nreset;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [2:0]  f_in;
  logic        ev;
  logic        sl;

  logic [3:0]  el;
  logic [3:0]  sv;
  logic [3:0]  res;
  logic [3:0]  err;
  logic [31:0] y [4];

  int errores;
  int checks;

  int unsigned digs [4] = '{8, 1, 4, 32};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned Dig = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;

    comparador_serie_if #(.ANCHO(32)) bus ();

    assign bus.a              = a_in;
    assign bus.b              = b_in;
    assign bus.funcion        = f_in;
    assign bus.entrada_valida = ev;
    assign bus.salida_lista   = sl;
    assign el[g]              = bus.entrada_lista;
    assign sv[g]              = bus.salida_valida;
    assign res[g]             = bus.resultado;
    assign err[g]             = bus.error;
    assign y[g]               = bus.Y;

    comparador_serie #(
      .ANCHO (32),
      .DIGITO(Dig)
    ) u_dut (
      .clk   (clk),
      .nreset(nreset),
      .bus   (bus)
    );
  end

  always #5 clk = ~clk;

  // Reference verdict straight from the branch/SLT semantics.
  function automatic logic modelo_res(input logic [31:0] x, input logic [31:0] z,
                                      input logic [2:0] f);
    case (f)
      F_EQ:    return x == z;
      F_NE:    return x != z;
      F_LT:    return $signed(x) < $signed(z);
      F_GE:    return $signed(x) >= $signed(z);
      F_LTU:   return x < z;
      F_GEU:   return x >= z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic modelo_err(input logic [2:0] f);
    return (f == 3'b010) || (f == 3'b011);
  endfunction

  // Cycles until result: N minus the slice holding the highest differing bit.
  function automatic int modelo_lat(input logic [31:0] x, input logic [31:0] z,
                                    input int unsigned dig);
    logic [31:0] dif;
    int          n;
    dif = x ^ z;
    n   = 32 / int'(dig);
    for (int p = 31; p >= 0; p--) begin
      if (dif[p]) return n - p / int'(dig);
    end
    return n;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (el !== 4'hF && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (el !== 4'hF) begin
      errores++;
      $display("FAIL wait_ready entrada_lista=%b expected 1111", el);
    end
  endtask

  task automatic run_txn(input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic [2:0] op_f, output logic r0, output logic [31:0] y0,
                         output logic e0, output int lat0);
    int          lat_obs [4];
    logic [3:0]  got;
    logic        r_obs [4];
    logic [31:0] y_obs [4];
    logic        e_obs [4];
    logic        r_exp;
    logic        e_exp;
    int          lat_exp;
    got = '0;
    for (int d = 0; d < 4; d++) begin
      lat_obs[d] = -1;
      r_obs[d]   = 1'b0;
      y_obs[d]   = '0;
      e_obs[d]   = 1'b0;
    end
    wait_ready();
    @(negedge clk);
    a_in = op_a; b_in = op_b; f_in = op_f; ev = 1'b1; sl = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (el !== 4'b0000) begin
      errores++;
      $display("FAIL busy_after_accept entrada_lista=%b expected 0000", el);
    end
    @(negedge clk);
    // Operand changes after the accept edge must not matter.
    ev = 1'b0; a_in = $urandom; b_in = $urandom; f_in = 3'($urandom);
    for (int c = 1; c <= 40 && got != 4'hF; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        if (sv[d] && !got[d]) begin
          got[d]     = 1'b1;
          lat_obs[d] = c;
          r_obs[d]   = res[d];
          y_obs[d]   = y[d];
          e_obs[d]   = err[d];
        end
      end
    end
    r_exp = modelo_res(op_a, op_b, op_f);
    e_exp = modelo_err(op_f);
    for (int d = 0; d < 4; d++) begin
      lat_exp = modelo_lat(op_a, op_b, digs[d]);
      checks++;
      if (lat_obs[d] != lat_exp) begin
        errores++;
        $display("FAIL latency dig=%0d a=%h b=%h f=%b got %0d expected %0d",
                 digs[d], op_a, op_b, op_f, lat_obs[d], lat_exp);
      end
      checks++;
      if (r_obs[d] !== r_exp || y_obs[d] !== 32'(r_exp) || e_obs[d] !== e_exp) begin
        errores++;
        $display("FAIL result dig=%0d a=%h b=%h f=%b got r=%b y=%h e=%b expected r=%b y=%h e=%b",
                 digs[d], op_a, op_b, op_f, r_obs[d], y_obs[d], e_obs[d],
                 r_exp, 32'(r_exp), e_exp);
      end
    end
    r0   = r_obs[0];
    y0   = y_obs[0];
    e0   = e_obs[0];
    lat0 = lat_obs[0];
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (el !== 4'hF || sv !== 4'h0 || res !== 4'h0 || err !== 4'h0 || y[0] !== 32'd0) begin
      errores++;
      $display("FAIL reset_low el=%b sv=%b res=%b err=%b y0=%h expected 1111 0000 0000 0000 0",
               el, sv, res, err, y[0]);
    end
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (el !== 4'hF || sv !== 4'h0 || y[1] !== 32'd0 || y[3] !== 32'd0) begin
      errores++;
      $display("FAIL reset_after el=%b sv=%b expected 1111 0000", el, sv);
    end
  endtask

  task automatic test_equal();
    logic r, e; logic [31:0] yy; int lat;
    run_txn(32'd112, 32'd112, F_EQ, r, yy, e, lat);
    checks++;
    if (r !== 1'b1 || yy !== 32'd1 || e !== 1'b0 || lat != 4) begin
      errores++;
      $display("FAIL eq_112 got r=%b y=%h e=%b lat=%0d expected 1 1 0 4", r, yy, e, lat);
    end
    run_txn(32'd112, 32'd112, F_NE, r, yy, e, lat);
    checks++;
    if (r !== 1'b0 || yy !== 32'd0 || lat != 4) begin
      errores++;
      $display("FAIL ne_112 got r=%b y=%h lat=%0d expected 0 0 4", r, yy, lat);
    end
  endtask

  task automatic test_signed();
    logic r, e; logic [31:0] yy; int lat;
    run_txn(32'hFFFF_FFFB, 32'd3, F_LT, r, yy, e, lat);
    checks++;
    if (r !== 1'b1 || lat != 1) begin
      errores++;
      $display("FAIL lt_neg5_3 got r=%b lat=%0d expected 1 1", r, lat);
    end
    run_txn(32'hFFFF_FFFB, 32'd3, F_LTU, r, yy, e, lat);
    checks++;
    if (r !== 1'b0 || lat != 1) begin
      errores++;
      $display("FAIL ltu_neg5_3 got r=%b lat=%0d expected 0 1", r, lat);
    end
    run_txn(32'hFFFF_FFFB, 32'd3, F_GEU, r, yy, e, lat);
    checks++;
    if (r !== 1'b1 || yy !== 32'd1) begin
      errores++;
      $display("FAIL geu_neg5_3 got r=%b y=%h expected 1 1", r, yy);
    end
  endtask

  task automatic test_low_slice();
    logic r, e; logic [31:0] yy; int lat;
    run_txn(32'h1234_5600, 32'h1234_5601, F_GE, r, yy, e, lat);
    checks++;
    if (r !== 1'b0 || lat != 4) begin
      errores++;
      $display("FAIL ge_low_slice got r=%b lat=%0d expected 0 4", r, lat);
    end
    run_txn(32'h1234_5600, 32'h1234_5601, F_LTU, r, yy, e, lat);
    checks++;
    if (r !== 1'b1 || lat != 4) begin
      errores++;
      $display("FAIL ltu_low_slice got r=%b lat=%0d expected 1 4", r, lat);
    end
  endtask

  task automatic test_invalid();
    logic r, e; logic [31:0] yy; int lat;
    run_txn(32'd7, 32'd9, 3'b010, r, yy, e, lat);
    checks++;
    if (e !== 1'b1 || r !== 1'b0 || yy !== 32'd0) begin
      errores++;
      $display("FAIL funct_010 got e=%b r=%b y=%h expected 1 0 0", e, r, yy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    wait_ready();
    @(negedge clk);
    a_in = 32'd5; b_in = 32'd9; f_in = F_LTU; ev = 1'b1; sl = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ev = 1'b0;
    n = 0;
    while (sv[0] !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sv[0] !== 1'b1) begin
      errores++;
      $display("FAIL bp_result_timeout salida_valida=%b expected 1", sv[0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ev = 1'b1; a_in = $urandom; b_in = $urandom; f_in = F_EQ;
      @(posedge clk);
      #1;
      checks++;
      if (sv[0] !== 1'b1 || res[0] !== 1'b1 || y[0] !== 32'd1 || el[0] !== 1'b0) begin
        errores++;
        $display("FAIL bp_hold cycle=%0d got sv=%b r=%b y=%h el=%b expected 1 1 1 0",
                 i, sv[0], res[0], y[0], el[0]);
      end
    end
    @(negedge clk);
    ev = 1'b0; sl = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sv[0] !== 1'b0 || el[0] !== 1'b1) begin
      errores++;
      $display("FAIL bp_release got sv=%b el=%b expected 0 1", sv[0], el[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sv[0] !== 1'b0 || el[0] !== 1'b1) begin
      errores++;
      $display("FAIL bp_ignored_request got sv=%b el=%b expected 0 1", sv[0], el[0]);
    end
  endtask

  task automatic test_reset_mid();
    wait_ready();
    @(negedge clk);
    a_in = 32'h55; b_in = 32'h55; f_in = F_EQ; ev = 1'b1; sl = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ev = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    nreset = 1'b0;
    #1;
    checks++;
    if (sv !== 4'h0 || el !== 4'hF || res !== 4'h0 || err !== 4'h0) begin
      errores++;
      $display("FAIL reset_mid got sv=%b el=%b res=%b err=%b expected 0000 1111 0000 0000",
               sv, el, res, err);
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sv !== 4'h0) begin
        errores++;
        $display("FAIL reset_mid_no_result cycle=%0d sv=%b expected 0000", i, sv);
      end
    end
  endtask

  task automatic test_random();
    logic r, e; logic [31:0] yy; int lat;
    logic [31:0] x, z;
    for (int i = 0; i < 240; i++) begin
      if (i < 120) begin
        x = 32'($urandom_range(2000)) - 32'd1000;
        z = 32'($urandom_range(2000)) - 32'd1000;
      end else begin
        x = $urandom;
        z = $urandom;
      end
      if ($urandom_range(7) == 0) z = x;
      else if ($urandom_range(7) == 0) z = x ^ (32'd1 << $urandom_range(31));
      run_txn(x, z, 3'($urandom_range(7)), r, yy, e, lat);
    end
  endtask

  initial begin
    clk = 1'b0; nreset = 1'b0; ev = 1'b0; sl = 1'b1;
    a_in = '0; b_in = '0; f_in = '0;
    errores = 0; checks = 0;
    test_reset();
    test_equal();
    test_signed();
    test_low_slice();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule

// File: doc/comparador_serie.md
# comparador_serie

Parametrised multi-cycle comparator for the RV32I datapath. It compares two `ANCHO`-bit operands `DIGITO` bits per cycle, starting at the most-significant slice, and stops early at the first differing slice. It evaluates every branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU), encoded directly by funct3, and returns both a 1-bit verdict and a zero-extended `ANCHO`-bit word usable for SLT/SLTU. It is the sequential, handshaked successor of the combinational set-less-than function: it serves the branch unit and the ALU, and trades latency for a narrow comparator slice.

## Interface
- `ANCHO`, 32: operand width; must be a multiple of `DIGITO`.
- `DIGITO`, 8: bits compared per cycle; 1 ≤ `DIGITO` ≤ `ANCHO`. The number of slices is N = `ANCHO`/`DIGITO`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `nreset`  in  1  reset, asynchronous and active-low.
- `a`  in  `ANCHO`  operand A; sampled only on an accepted input.
- `b`  in  `ANCHO`  operand B; sampled only on an accepted input.
- `funcion`  in  3  RV32I funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
- `entrada_valida`  in  1  request valid.
- `entrada_lista`  out  1  ready to accept a request.
- `salida_valida`  out  1  result valid.
- `salida_lista`  in  1  consumer accepts the result.
- `resultado`  out  1  condition true.
- `Y`  out  `ANCHO`  {`ANCHO`-1 zeros, `resultado`}.
- `error`  out  1  `funcion` was 010 or 011.

## Operation
- FSM states:
  - INACTIVO: `entrada_lista`=1. On `entrada_valida`&&`entrada_lista`, latch `a`, `b` and `funcion`, set idx=N-1, and go to COMPARANDO.
  - COMPARANDO: compare slice idx of the latched operands.
    - If the slices differ, or idx==0: register `resultado`/`error` and go to RESULTADO.
    - Otherwise decrement idx.
  - RESULTADO: `salida_valida`=1 and the outputs are held stable. On `salida_lista`, return to INACTIVO.
- Signed modes (LT/GE): the sign bit (bit `ANCHO`-1) of both operands is inverted at latch time, and the comparison then runs unsigned.
- Decision:
  - The first differing slice decides lt/gt.
  - If every slice is equal, eq=1.
  - EQ=eq, NE=!eq, LT/LTU=lt, GE/GEU=!lt.
- Invalid `funcion` (010, 011): the transaction still runs to completion, with `resultado`=0 and `error`=1.
- There is at most one outstanding transaction. `entrada_lista` is 0 in COMPARANDO and RESULTADO, and `entrada_valida` is ignored there.

## Timing
- Reset values: `salida_valida`=0, `resultado`=0, `Y`=0, `error`=0, state INACTIVO, so `entrada_lista`=1 with `nreset` low and after it.
- Latency: k cycles from the accept edge to the first cycle with `salida_valida`=1.
  - k = N - j, where j is the index of the most-significant differing slice.
  - k = N when the operands are equal.
  - Minimum 1 cycle, maximum N.
- `DIGITO`=`ANCHO`: always 1 cycle.
- `entrada_lista` is combinational from state only; it has no combinational path from `entrada_valida`.
- Backpressure: `salida_lista`=0 holds RESULTADO indefinitely, with `resultado`/`Y`/`error` unchanged.
- The result handshake and a new input never share an edge. `entrada_lista` rises in the cycle after the output handshake, so throughput is at most one result per k+1 cycles.
- `nreset` asserted mid-transaction aborts it immediately: no result is produced and all outputs return to their reset values.
- Changes on `a`, `b` and `funcion` after the accept edge have no effect.

## Structure
- Package `paquete_comparador` holds:
  - localparams for the funct3 codes (`F_EQ`, `F_NE`, `F_LT`, `F_GE`, `F_LTU`, `F_GEU`);
  - the state encoding (INACTIVO, COMPARANDO, RESULTADO);
  - the function `es_con_signo(funcion)`.
- Sub-module `comparador_digito`: combinational unsigned `DIGITO`-bit slice compare, with outputs `menor` and `igual`. It is instantiated once.
- The top level holds the FSM, the operand registers, the idx counter (width $clog2(N), minimum 1) and the result registers.

## Test plan
All scenarios use `ANCHO`=32 and `DIGITO`=8 (N=4) unless stated otherwise.
- a=112, b=112, EQ → `resultado`=1, `Y`=1, `error`=0; `salida_valida` rises 4 cycles after accept. The same operands with NE → 0 after 4 cycles.
- a=0xFFFFFFFB (-5), b=3 → LT gives 1 after 1 cycle; LTU gives 0 after 1 cycle; GEU gives 1.
- a=0x12345600, b=0x12345601 → GE gives 0 after 4 cycles; LTU gives 1 after 4 cycles.
- Hold `salida_lista`=0 for 3 cycles in RESULTADO while pulsing `entrada_valida` → outputs stable, `entrada_lista`=0, the request is ignored; the handshake completes on the 4th cycle.
- `nreset` pulsed low during COMPARANDO (idx=2) → `salida_valida`=0 and `entrada_lista`=1 immediately; no result appears afterwards.
- `funcion`=010 → `error`=1, `resultado`=0.
- Randomised run: operands in ±1000 and full 32-bit range, checked against a behavioural model at `DIGITO`=1, 4 and 32, including latency.
